// File: rtl/reservation_station.sv
// Reservation station with CDB wakeup, dispatch bypass and oldest-ready issue select.
// Ages saturate at RS_SIZE-1, so ties among saturated entries fall back to the lower index.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module reservation_station #(
    parameter int RS_SIZE = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       dispatch_valid,
    input  logic [`ROB_TAG_LEN-1:0]    dispatch_rob_tag,
    input  logic                       src1_valid,
    input  logic                       src2_valid,
    input  logic [`ROB_TAG_LEN-1:0]    src1_tag,
    input  logic [`ROB_TAG_LEN-1:0]    src2_tag,
    input  logic [DATA_W-1:0]          src1_value,
    input  logic [DATA_W-1:0]          src2_value,
    input  logic                       cdb_valid,
    input  logic [`ROB_TAG_LEN-1:0]    cdb_tag,
    input  logic [DATA_W-1:0]          cdb_value,
    input  logic                       issue_en,
    output logic                       insn_ready,
    output logic [`ROB_TAG_LEN-1:0]    rob_tag_out,
    output logic [DATA_W-1:0]          op1_out,
    output logic [DATA_W-1:0]          op2_out,
    output logic                       full,
    output logic [$clog2(RS_SIZE):0]   free_count
);

    localparam int IDX_W = $clog2(RS_SIZE);
    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = `ROB_TAG_LEN;
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(RS_SIZE - 1);

    logic [RS_SIZE-1:0] valid_q, valid_d;
    logic [RS_SIZE-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [TAG_W-1:0]   rob_tag_q [RS_SIZE];
    logic [TAG_W-1:0]   rob_tag_d [RS_SIZE];
    logic [TAG_W-1:0]   tag1_q [RS_SIZE];
    logic [TAG_W-1:0]   tag1_d [RS_SIZE];
    logic [TAG_W-1:0]   tag2_q [RS_SIZE];
    logic [TAG_W-1:0]   tag2_d [RS_SIZE];
    logic [DATA_W-1:0]  val1_q [RS_SIZE];
    logic [DATA_W-1:0]  val1_d [RS_SIZE];
    logic [DATA_W-1:0]  val2_q [RS_SIZE];
    logic [DATA_W-1:0]  val2_d [RS_SIZE];
    logic [IDX_W-1:0]   age_q [RS_SIZE];
    logic [IDX_W-1:0]   age_d [RS_SIZE];

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   sel_age;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [CNT_W-1:0]   free_cnt;
    logic               accept;
    logic               issue;

    // Select and free-slot search look only at registered state.
    always_comb begin
        sel_found  = 1'b0;
        sel_idx    = '0;
        sel_age    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        free_cnt   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && rdy1_q[i] && rdy2_q[i] &&
                (!sel_found || age_q[i] > sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_age   = age_q[i];
            end
            if (!valid_q[i]) begin
                free_cnt = free_cnt + CNT_W'(1);
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(i);
                end
            end
        end
    end

    always_comb begin
        insn_ready  = sel_found;
        rob_tag_out = '0;
        op1_out     = '0;
        op2_out     = '0;
        if (sel_found) begin
            rob_tag_out = rob_tag_q[sel_idx];
            op1_out     = val1_q[sel_idx];
            op2_out     = val2_q[sel_idx];
        end
        full       = !free_found;
        free_count = free_cnt;
    end

    always_comb begin
        valid_d   = valid_q;
        rdy1_d    = rdy1_q;
        rdy2_d    = rdy2_q;
        rob_tag_d = rob_tag_q;
        tag1_d    = tag1_q;
        tag2_d    = tag2_q;
        val1_d    = val1_q;
        val2_d    = val2_q;
        age_d     = age_q;
        accept    = dispatch_valid && free_found && !squash;
        issue     = issue_en && sel_found && !squash;

        if (squash) begin
            valid_d = '0;
        end else begin
            if (issue) begin
                valid_d[sel_idx] = 1'b0;
            end
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (valid_q[i] && cdb_valid) begin
                    if (!rdy1_q[i] && tag1_q[i] == cdb_tag) begin
                        rdy1_d[i] = 1'b1;
                        val1_d[i] = cdb_value;
                    end
                    if (!rdy2_q[i] && tag2_q[i] == cdb_tag) begin
                        rdy2_d[i] = 1'b1;
                        val2_d[i] = cdb_value;
                    end
                end
                if (accept && valid_q[i] && age_q[i] != AGE_MAX) begin
                    age_d[i] = age_q[i] + IDX_W'(1);
                end
            end
            // The allocated slot is invalid in the current state, so it never collides with wakeup or issue.
            if (accept) begin
                valid_d[free_idx]   = 1'b1;
                rob_tag_d[free_idx] = dispatch_rob_tag;
                age_d[free_idx]     = '0;
                tag1_d[free_idx]    = src1_tag;
                tag2_d[free_idx]    = src2_tag;
                rdy1_d[free_idx]    = src1_valid || (cdb_valid && cdb_tag == src1_tag);
                rdy2_d[free_idx]    = src2_valid || (cdb_valid && cdb_tag == src2_tag);
                val1_d[free_idx]    = src1_valid ? src1_value : cdb_value;
                val2_d[free_idx]    = src2_valid ? src2_value : cdb_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            rdy1_q  <= '0;
            rdy2_q  <= '0;
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                rob_tag_q[i] <= '0;
                tag1_q[i]    <= '0;
                tag2_q[i]    <= '0;
                val1_q[i]    <= '0;
                val2_q[i]    <= '0;
                age_q[i]     <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            rdy1_q    <= rdy1_d;
            rdy2_q    <= rdy2_d;
            rob_tag_q <= rob_tag_d;
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
            val1_q    <= val1_d;
            val2_q    <= val2_d;
            age_q     <= age_d;
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus random traffic against a slot/sequence-number model.

`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module tb_reservation_station;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = `ROB_TAG_LEN;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          reset, squash, dispatch_valid;
    logic [TW-1:0] dispatch_rob_tag, src1_tag, src2_tag, cdb_tag;
    logic          src1_valid, src2_valid, cdb_valid, issue_en;
    logic [DW-1:0] src1_value, src2_value, cdb_value;
    logic          insn_ready, full;
    logic [TW-1:0] rob_tag_out;
    logic [DW-1:0] op1_out, op2_out;
    logic [CW-1:0] free_count;

    reservation_station #(.RS_SIZE(N), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .squash(squash),
        .dispatch_valid(dispatch_valid), .dispatch_rob_tag(dispatch_rob_tag),
        .src1_valid(src1_valid), .src2_valid(src2_valid),
        .src1_tag(src1_tag), .src2_tag(src2_tag),
        .src1_value(src1_value), .src2_value(src2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_en(issue_en), .insn_ready(insn_ready), .rob_tag_out(rob_tag_out),
        .op1_out(op1_out), .op2_out(op2_out), .full(full), .free_count(free_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: each slot remembers the dispatch sequence number it was allocated at;
    // age is the number of later accepted dispatches, capped at N-1.
    bit            m_v  [N];
    bit            m_r1 [N];
    bit            m_r2 [N];
    logic [TW-1:0] m_tag[N];
    logic [TW-1:0] m_t1 [N];
    logic [TW-1:0] m_t2 [N];
    logic [DW-1:0] m_o1 [N];
    logic [DW-1:0] m_o2 [N];
    int            m_seq[N];
    int            m_dcount = 0;

    function automatic int m_age(input int i);
        int a = m_dcount - m_seq[i];
        return (a > N - 1) ? N - 1 : a;
    endfunction

    function automatic int m_sel();
        int best = -1;
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_r1[i] && m_r2[i])
                if (best < 0 || m_age(i) > m_age(best)) best = i;
        return best;
    endfunction

    function automatic int m_free_slot();
        for (int i = 0; i < N; i++) if (!m_v[i]) return i;
        return -1;
    endfunction

    function automatic int m_free_count();
        int c = 0;
        for (int i = 0; i < N; i++) if (!m_v[i]) c++;
        return c;
    endfunction

    task automatic model_update();
        int s = m_sel();
        int f = m_free_slot();
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_v[i] = 0; m_r1[i] = 0; m_r2[i] = 0;
            end
            m_dcount = 0;
        end else if (squash) begin
            for (int i = 0; i < N; i++) m_v[i] = 0;
        end else begin
            if (issue_en && s >= 0) m_v[s] = 0;
            for (int i = 0; i < N; i++) begin
                if (m_v[i] && cdb_valid && !m_r1[i] && m_t1[i] == cdb_tag) begin
                    m_r1[i] = 1; m_o1[i] = cdb_value;
                end
                if (m_v[i] && cdb_valid && !m_r2[i] && m_t2[i] == cdb_tag) begin
                    m_r2[i] = 1; m_o2[i] = cdb_value;
                end
            end
            if (dispatch_valid && f >= 0) begin
                m_dcount++;
                m_v[f]   = 1;
                m_seq[f] = m_dcount;
                m_tag[f] = dispatch_rob_tag;
                m_t1[f]  = src1_tag;
                m_t2[f]  = src2_tag;
                m_r1[f]  = src1_valid || (cdb_valid && cdb_tag == src1_tag);
                m_r2[f]  = src2_valid || (cdb_valid && cdb_tag == src2_tag);
                m_o1[f]  = src1_valid ? src1_value : cdb_value;
                m_o2[f]  = src2_valid ? src2_value : cdb_value;
            end
        end
    endtask

    task automatic check_outputs();
        int s = m_sel();
        logic [TW-1:0] e_tag = '0;
        logic [DW-1:0] e_o1 = '0, e_o2 = '0;
        if (s >= 0) begin
            e_tag = m_tag[s]; e_o1 = m_o1[s]; e_o2 = m_o2[s];
        end
        check("insn_ready", 64'(insn_ready), 64'(s >= 0));
        check("rob_tag_out", 64'(rob_tag_out), 64'(e_tag));
        check("op1_out", 64'(op1_out), 64'(e_o1));
        check("op2_out", 64'(op2_out), 64'(e_o2));
        check("full", 64'(full), 64'(m_free_count() == 0));
        check("free_count", 64'(free_count), 64'(m_free_count()));
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        reset = 0; squash = 0; dispatch_valid = 0; dispatch_rob_tag = '0;
        src1_valid = 0; src2_valid = 0; src1_tag = '0; src2_tag = '0;
        src1_value = '0; src2_value = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_value = '0; issue_en = 0;
    endtask

    task automatic disp(input logic [TW-1:0] t, input logic v1, input logic [TW-1:0] t1,
                        input logic [DW-1:0] x1, input logic v2, input logic [TW-1:0] t2,
                        input logic [DW-1:0] x2);
        dispatch_valid = 1; dispatch_rob_tag = t;
        src1_valid = v1; src1_tag = t1; src1_value = x1;
        src2_valid = v2; src2_tag = t2; src2_value = x2;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        check("rst_free_count", 64'(free_count), 64'(N));
        check("rst_insn_ready", 64'(insn_ready), 64'(0));

        // Both operands available
        idle(); disp(5, 1, 0, 3, 1, 0, 4); step();
        check("d21_ready", 64'(insn_ready), 64'(1));
        check("d21_tag", 64'(rob_tag_out), 64'(5));
        check("d21_op1", 64'(op1_out), 64'(3));
        check("d21_op2", 64'(op2_out), 64'(4));
        idle(); issue_en = 1; step();
        check("d21_issued", 64'(insn_ready), 64'(0));
        check("d21_free", 64'(free_count), 64'(4));

        // Wakeup through CDB
        idle(); disp(7, 0, 2, 0, 1, 0, 1); step();
        check("d22_wait", 64'(insn_ready), 64'(0));
        idle(); step();
        idle(); cdb_valid = 1; cdb_tag = 2; cdb_value = 32'hAB; step();
        check("d22_ready", 64'(insn_ready), 64'(1));
        check("d22_op1", 64'(op1_out), 64'hAB);
        idle(); issue_en = 1; step();

        // Dispatch bypass from CDB
        idle(); disp(8, 1, 0, 6, 0, 9, 0); cdb_valid = 1; cdb_tag = 9; cdb_value = 32'h11; step();
        check("d23_ready", 64'(insn_ready), 64'(1));
        check("d23_op2", 64'(op2_out), 64'h11);
        idle(); issue_en = 1; step();

        // Fill, overflow dispatch, then issue in age order
        for (int k = 0; k < N; k++) begin
            idle(); disp(TW'(10 + k), 1, 0, 32'(k), 1, 0, 32'(k + 100)); step();
        end
        check("d24_full", 64'(full), 64'(1));
        check("d24_free0", 64'(free_count), 64'(0));
        idle(); disp(14, 1, 0, 1, 1, 0, 1); step();
        check("d24_dropped", 64'(free_count), 64'(0));
        check("d24_oldest", 64'(rob_tag_out), 64'(10));
        idle(); issue_en = 1; disp(15, 1, 0, 1, 1, 0, 1); step();
        check("d25_free1", 64'(free_count), 64'(1));
        for (int k = 1; k < N; k++) begin
            check("d24_order", 64'(rob_tag_out), 64'(10 + k));
            idle(); issue_en = 1; step();
        end

        // Squash overrides concurrent dispatch and CDB
        idle(); disp(20, 0, 30, 0, 1, 0, 1); step();
        idle(); disp(21, 0, 30, 0, 1, 0, 1); step();
        idle(); squash = 1; disp(22, 1, 0, 1, 1, 0, 1);
        cdb_valid = 1; cdb_tag = 30; cdb_value = 5; step();
        check("d26_free", 64'(free_count), 64'(N));
        check("d26_ready", 64'(insn_ready), 64'(0));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            idle();
            reset          = ($urandom_range(0, 199) == 0);
            squash         = ($urandom_range(0, 39) == 0);
            dispatch_valid = ($urandom_range(0, 9) < 6);
            dispatch_rob_tag = TW'($urandom);
            src1_valid = $urandom_range(0, 1) == 1;
            src2_valid = $urandom_range(0, 1) == 1;
            src1_tag   = TW'($urandom_range(0, 7));
            src2_tag   = TW'($urandom_range(0, 7));
            src1_value = $urandom;
            src2_value = $urandom;
            cdb_valid  = $urandom_range(0, 1) == 1;
            cdb_tag    = TW'($urandom_range(0, 7));
            cdb_value  = $urandom;
            issue_en   = ($urandom_range(0, 9) < 4);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
